mreg_reader: RTL and testbench
==============================

MREG_READER -- requirements
Module: mreg_reader

Interface
REQ-001 SHALL have parameter I_WIDTH, default 8: integer bits of each entry.
REQ-002 SHALL have parameter F_WIDTH, default 8: fractional bits of each entry; W = I_WIDTH+F_WIDTH.
REQ-003 SHALL have parameter N, default 3: number of register-file entries.
REQ-004 SHALL have parameter ADDRS_WIDTH, default $clog2(N): address width.
REQ-005 SHALL have parameter REP_WIDTH, default 4: width of the repeat count.
REQ-006 SHALL have port clk_i, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port start_i, input, 1 bit: request a read burst; sampled only in IDLE.
REQ-009 SHALL have port len_i, input, ADDRS_WIDTH+1 bits: entries per pass.
REQ-010 SHALL have port rep_i, input, REP_WIDTH bits: extra passes; total passes P = rep_i+1.
REQ-011 SHALL have port mreg_rd_addrs_o, output, ADDRS_WIDTH bits: read address to the register file.
REQ-012 SHALL have port rd_data_i, input, W bits, signed: combinational read data at mreg_rd_addrs_o.
REQ-013 SHALL have port data_o, output, W bits, signed: streamed entry.
REQ-014 SHALL have port data_addrs_o, output, ADDRS_WIDTH bits: source address of data_o.
REQ-015 SHALL have port valid_o, output, 1 bit: data_o/data_addrs_o valid.
REQ-016 SHALL have port ready_i, input, 1 bit: downstream accepts the beat when valid_o&&ready_i.
REQ-017 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.
REQ-018 SHALL have port done_o, output, 1 bit: one-cycle pulse at burst end.

Function
REQ-019 FSM SHALL have states IDLE, READ, DRAIN, DONE.
REQ-020 IDLE with start_i=1 SHALL latch L = min(len_i,N) and P, clear the address and pass counters, and go to READ; start_i SHALL be ignored outside IDLE.
REQ-021 If L=0, IDLE with start_i=1 SHALL go directly to DONE, emitting no beats.
REQ-022 In READ, the output slot is free when valid_o=0 or ready_i=1; on a free slot, the block SHALL load data_o<=rd_data_i and data_addrs_o<=mreg_rd_addrs_o, set valid_o<=1, and advance the address.
REQ-023 At address L-1, the address SHALL wrap to 0 and the pass counter SHALL increment; after the last entry of pass P, the FSM SHALL go to DRAIN.
REQ-024 With the slot stalled (valid_o=1, ready_i=0), data_o, data_addrs_o, valid_o and the address SHALL hold.
REQ-025 DRAIN SHALL wait for a free slot, then clear valid_o and go to DONE.
REQ-026 DONE SHALL assert done_o for exactly one cycle and return to IDLE.
REQ-027 Timing: with start_i accepted at cycle t and ready_i held high, the FSM SHALL be in READ at t+1; valid_o SHALL be high from t+2 for L*P consecutive cycles; done_o SHALL be high at t+2+L*P.
REQ-028 Data SHALL pass through unmodified (no width change, sign preserved).

Reset
REQ-029 rst_n_i=0 SHALL asynchronously force IDLE and clear the counters, and SHALL drive mreg_rd_addrs_o=0, data_o=0, data_addrs_o=0, valid_o=0, busy_o=0, done_o=0.
REQ-030 A reset mid-burst SHALL abandon the burst with no done_o; after release, the block SHALL require a new start_i.

Configuration
REQ-031 With MREG_READER_ZERO_SKIP_EN defined, READ SHALL advance past an entry with rd_data_i==0 without setting valid_o (one cycle per skipped entry), and done_o timing SHALL shift accordingly.
REQ-032 Without MREG_READER_ZERO_SKIP_EN, every entry SHALL be emitted, including zeros.

Structure
REQ-033 Package mreg_pkg SHALL hold the FSM state encoding constants (IDLE, READ, DRAIN, DONE) and the default width constants shared with mul_reg users.
REQ-034 The output register stage (data/addrs/valid hold logic) SHALL be the sub-module mreg_out_stage; the FSM and counters SHALL stay in mreg_reader.

Verification
REQ-035 N=3, entries {5,-2,7}, len=3, rep=0, ready=1 -> beats 5,-2,7 with addrs 0,1,2 at t+2..t+4; done_o at t+5.
REQ-036 len=2, rep=2, ready=1 -> beats addrs 0,1,0,1,0,1; done_o at t+8.
REQ-037 len=3, ready low for 3 cycles after the first beat -> data_o=5 held 4 cycles; beat order unchanged; no loss or duplication.
REQ-038 len=0 -> no valid_o; done_o at t+1; len=7 with N=3 -> clamped to 3 beats.
REQ-039 rst_n_i low mid-burst (after beat 1) -> all outputs 0 immediately, no done_o; a new start_i restarts from addr 0.
REQ-040 ZERO_SKIP_EN, entries {0,4,0}, len=3 -> single beat 4 with addr 1; done_o follows.

Source files
------------

// File: rtl/mreg_pkg.sv
// Shared constants for the mul_reg read path: FSM state encoding and default entry geometry.
package mreg_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int MREG_I_WIDTH   = 8;
    localparam int MREG_F_WIDTH   = 8;
    localparam int MREG_N         = 3;
    localparam int MREG_REP_WIDTH = 4;

endpackage

// File: rtl/mreg_out_stage.sv
// Output register slot for mreg_reader: holds data/address/valid while downstream stalls.
module mreg_out_stage #(
    parameter int W  = 16,
    parameter int AW = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 load_i,
    input  logic                 load_vld_i,
    input  logic                 clr_i,
    input  logic                 ready_i,
    input  logic signed [W-1:0]  data_i,
    input  logic [AW-1:0]        addr_i,
    output logic signed [W-1:0]  data_o,
    output logic [AW-1:0]        addr_o,
    output logic                 valid_o,
    output logic                 slot_free_o
);

    logic signed [W-1:0] data_q, data_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                valid_q, valid_d;

    assign slot_free_o = !valid_q || ready_i;

    // A load with load_vld_i=0 (skipped entry) still retires the current beat.
    always_comb begin
        data_d  = data_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        if (load_i) begin
            valid_d = load_vld_i;
            if (load_vld_i) begin
                data_d = data_i;
                addr_d = addr_i;
            end
        end else if (clr_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign addr_o  = addr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/mreg_reader.sv
// Streams L entries of a register file P times through a valid/ready slot.
// Define MREG_READER_ZERO_SKIP_EN to drop zero-valued entries instead of emitting them.
module mreg_reader
    import mreg_pkg::*;
#(
    parameter int I_WIDTH     = MREG_I_WIDTH,
    parameter int F_WIDTH     = MREG_F_WIDTH,
    parameter int N           = MREG_N,
    parameter int ADDRS_WIDTH = $clog2(N),
    parameter int REP_WIDTH   = MREG_REP_WIDTH
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic                                 start_i,
    input  logic [ADDRS_WIDTH:0]                 len_i,
    input  logic [REP_WIDTH-1:0]                 rep_i,
    output logic [ADDRS_WIDTH-1:0]               mreg_rd_addrs_o,
    input  logic signed [I_WIDTH+F_WIDTH-1:0]    rd_data_i,
    output logic signed [I_WIDTH+F_WIDTH-1:0]    data_o,
    output logic [ADDRS_WIDTH-1:0]               data_addrs_o,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic                                 busy_o,
    output logic                                 done_o
);

    localparam int W = I_WIDTH + F_WIDTH;
    localparam logic [ADDRS_WIDTH:0] N_CAP = (ADDRS_WIDTH+1)'(N);
    localparam logic [ADDRS_WIDTH:0] ONE   = (ADDRS_WIDTH+1)'(1);

    logic [1:0]             state_q, state_d;
    logic [ADDRS_WIDTH-1:0] addr_q, addr_d;
    logic [ADDRS_WIDTH:0]   len_q, len_d;
    logic [REP_WIDTH-1:0]   rep_q, rep_d;
    logic [REP_WIDTH-1:0]   pass_q, pass_d;

    logic                   slot_free;
    logic                   load_en;
    logic                   clr_vld;
    logic                   is_zero;
    logic                   last_addr;
    logic                   last_pass;
    logic [ADDRS_WIDTH:0]   len_clamped;

    assign len_clamped = (len_i > N_CAP) ? N_CAP : len_i;
    assign last_addr   = ({1'b0, addr_q} == (len_q - ONE));
    assign last_pass   = (pass_q == rep_q);

`ifdef MREG_READER_ZERO_SKIP_EN
    assign is_zero = (rd_data_i == '0);
`else
    assign is_zero = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        rep_d   = rep_q;
        pass_d  = pass_q;
        load_en = 1'b0;
        clr_vld = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d   = len_clamped;
                    rep_d   = rep_i;
                    addr_d  = '0;
                    pass_d  = '0;
                    state_d = (len_clamped == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (slot_free) begin
                    load_en = 1'b1;
                    if (last_addr) begin
                        addr_d = '0;
                        pass_d = pass_q + 1'b1;
                        if (last_pass) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (slot_free) begin
                    clr_vld = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            pass_q  <= pass_d;
        end
    end

    mreg_out_stage #(
        .W  (W),
        .AW (ADDRS_WIDTH)
    ) u_out (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .load_i      (load_en),
        .load_vld_i  (!is_zero),
        .clr_i       (clr_vld),
        .ready_i     (ready_i),
        .data_i      (rd_data_i),
        .addr_i      (addr_q),
        .data_o      (data_o),
        .addr_o      (data_addrs_o),
        .valid_o     (valid_o),
        .slot_free_o (slot_free)
    );

    assign mreg_rd_addrs_o = addr_q;
    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = (state_q == S_DONE);

endmodule

// File: tb/tb_mreg_reader.sv
// Scoreboard bench for mreg_reader: model builds the expected beat list per burst, a monitor pops it.
module tb_mreg_reader;

    localparam int NE = 3;

    logic               clk_i = 1'b0;
    logic               rst_n_i = 1'b0;
    logic               start_i = 1'b0;
    logic [2:0]         len_i = '0;
    logic [3:0]         rep_i = '0;
    logic [1:0]         mreg_rd_addrs_o;
    logic signed [15:0] rd_data_i;
    logic signed [15:0] data_o;
    logic [1:0]         data_addrs_o;
    logic               valid_o;
    logic               ready_i = 1'b1;
    logic               busy_o;
    logic               done_o;

    int mem [NE];
    int exp_data[$];
    int exp_addr[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_lo = 1, stall_hi = 0;
    bit rnd_rdy = 1'b0;
    int first_vld = -1;
    int beats = 0;
    int hold_cnt = 0;
    int exp_first_k, exp_l, exp_p;

    mreg_reader dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .start_i         (start_i),
        .len_i           (len_i),
        .rep_i           (rep_i),
        .mreg_rd_addrs_o (mreg_rd_addrs_o),
        .rd_data_i       (rd_data_i),
        .data_o          (data_o),
        .data_addrs_o    (data_addrs_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    assign rd_data_i = (mreg_rd_addrs_o < NE) ? 16'(mem[mreg_rd_addrs_o]) : 16'sd0;

    always @(posedge clk_i) begin
        #1;
        if (cyc >= stall_lo && cyc <= stall_hi) ready_i = 1'b0;
        else if (rnd_rdy)                        ready_i = 1'($urandom_range(0, 1));
        else                                     ready_i = 1'b1;
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted beat must be the next one the model predicted.
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (valid_o && first_vld < 0) first_vld = cyc;
            if (valid_o && data_addrs_o == 2'd0 && int'(data_o) == mem[0]) hold_cnt++;
            if (valid_o && ready_i) begin
                beats++;
                if (exp_data.size() == 0) begin
                    chk(1'b0, "unexpected_beat", int'(data_o), 0);
                end else begin
                    int ed, ea;
                    ed = exp_data.pop_front();
                    ea = exp_addr.pop_front();
                    chk(int'(data_o) == ed, "beat_data", int'(data_o), ed);
                    chk(int'(data_addrs_o) == ea, "beat_addr", int'(data_addrs_o), ea);
                end
            end
        end
    end

    // Reference: P passes over the first min(len,N) entries, zeros dropped when skipping.
    task automatic build_expected(input int len, input int rep);
        int k;
        exp_l = (len > NE) ? NE : len;
        exp_p = rep + 1;
        exp_first_k = -1;
        k = 0;
        for (int p = 0; p < exp_p; p++) begin
            for (int a = 0; a < exp_l; a++) begin
`ifdef MREG_READER_ZERO_SKIP_EN
                if (mem[a] != 0) begin
                    if (exp_first_k < 0) exp_first_k = k;
                    exp_data.push_back(mem[a]);
                    exp_addr.push_back(a);
                end
`else
                if (exp_first_k < 0) exp_first_k = k;
                exp_data.push_back(mem[a]);
                exp_addr.push_back(a);
`endif
                k++;
            end
        end
    endtask

    task automatic run_burst(input int len, input int rep, input bit chk_time, input bit stall, input bit noise);
        int t, dc;
        bit got;
        build_expected(len, rep);
        first_vld = -1;
        hold_cnt  = 0;
        @(posedge clk_i); #1;
        start_i = 1'b1; len_i = 3'(len); rep_i = 4'(rep);
        t = cyc;
        if (stall) begin stall_lo = t + 2; stall_hi = t + 4; end
        @(posedge clk_i); #1;
        start_i = 1'b0; len_i = 3'($urandom_range(0, 7)); rep_i = 4'($urandom_range(0, 15));
        if (chk_time) chk(busy_o == 1'b1, "busy_after_start", busy_o, 1);
        got = 1'b0;
        dc  = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                got = 1'b1;
                dc  = cyc;
                start_i = 1'b0;
            end else if (noise) begin
                start_i = 1'($urandom_range(0, 1));
            end
        end
        chk(got, "done_seen", got, 1);
        if (chk_time) begin
            int exp_dc;
            exp_dc = (exp_l == 0) ? t + 1 : t + 2 + exp_l * exp_p + (stall ? 3 : 0);
            chk(dc == exp_dc, "done_cycle", dc - t, exp_dc - t);
            if (exp_first_k >= 0)
                chk(first_vld == t + 2 + exp_first_k, "first_valid_cycle", first_vld - t, 2 + exp_first_k);
            else
                chk(first_vld < 0, "no_valid_expected", first_vld, -1);
        end
        if (stall) chk(hold_cnt == 4, "stall_hold_cycles", hold_cnt, 4);
        @(negedge clk_i);
        chk(!done_o && !busy_o, "done_single_pulse", {done_o, busy_o}, 0);
        chk(exp_data.size() == 0, "no_lost_beats", exp_data.size(), 0);
        stall_lo = 1; stall_hi = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        mem[0] = 5; mem[1] = -2; mem[2] = 7;
        #23;
        chk({valid_o, busy_o, done_o} == 3'b000, "reset_ctrl", {valid_o, busy_o, done_o}, 0);
        chk(data_o == 0 && data_addrs_o == 0 && mreg_rd_addrs_o == 0, "reset_data", data_o, 0);
        @(negedge clk_i); rst_n_i = 1'b1;
        repeat (2) @(posedge clk_i);

        run_burst(3, 0, 1'b1, 1'b0, 1'b0);   // 5,-2,7
        run_burst(2, 2, 1'b1, 1'b0, 1'b0);   // 0,1 x3
        run_burst(3, 0, 1'b1, 1'b1, 1'b0);   // stall on first beat
        run_burst(0, 0, 1'b1, 1'b0, 1'b0);   // empty burst
        run_burst(7, 0, 1'b1, 1'b0, 1'b0);   // clamp to N

        // Mid-burst reset: abandon after the first accepted beat.
        build_expected(3, 0);
        beats = 0;
        @(posedge clk_i); #1;
        start_i = 1'b1; len_i = 3'd3; rep_i = 4'd0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int i = 0; i < 50 && beats < 1; i++) @(negedge clk_i);
        chk(beats >= 1, "first_beat_before_reset", beats, 1);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk({valid_o, busy_o, done_o} == 3'b000, "async_reset_ctrl", {valid_o, busy_o, done_o}, 0);
        chk(data_o == 0 && data_addrs_o == 0 && mreg_rd_addrs_o == 0, "async_reset_data", data_o, 0);
        exp_data.delete();
        exp_addr.delete();
        repeat (3) @(negedge clk_i);
        #2 rst_n_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk(!done_o && !busy_o, "idle_after_reset", {done_o, busy_o}, 0);
        end
        run_burst(3, 0, 1'b1, 1'b0, 1'b0);

        mem[0] = 0; mem[1] = 4; mem[2] = 0;
        run_burst(3, 0, 1'b1, 1'b0, 1'b0);

        rnd_rdy = 1'b1;
        for (int it = 0; it < 25; it++) begin
            for (int a = 0; a < NE; a++)
                mem[a] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 600)) - 300;
            run_burst(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b1);
        end
        rnd_rdy = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
